// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
//   Single-clock FIFO with generic width and depth (the depth need not be a
//   power of two). It adds a fill count, run-time programmable almost-full and
//   almost-empty thresholds, and a defined pass-through when the FIFO is full
//   and a read and a write arrive together.
//
//   Optional feature macro: FIFO_FWFT_EN
//     defined   : first-word-fall-through. data_out shows mem[rd_ptr]
//                 combinationally whenever the FIFO is not empty, and reads
//                 0 while it is empty. rd_en pops the word currently shown.
//     undefined : standard mode. data_out is registered and is loaded on the
//                 clock edge of an accepted read, so read latency is 1 cycle.
//
// Parameters
//   FIFO_WIDTH  data width in bits
//   FIFO_DEPTH  number of entries (>=2)
//   CNT_W       width of the count and threshold buses (derived)
//
// Ports
//   clk          clock; all logic is on the rising edge
//   rst_n        synchronous reset, active-low
//   data_in      write data
//   wr_en        write request
//   rd_en        read request
//   af_thresh    almost-full threshold  (almostfull  = count >= af_thresh)
//   ae_thresh    almost-empty threshold (almostempty = count <= ae_thresh)
//   data_out     read data
//   wr_ack       pulse: the previous cycle's write was accepted
//   overflow     pulse: the previous cycle's write was rejected because full
//   underflow    pulse: the previous cycle's read was rejected because empty
//   full, empty  fill status, decoded from count
//   almostfull   threshold flag, decoded from count
//   almostempty  threshold flag, decoded from count
//   count        number of entries currently stored
// -----------------------------------------------------------------------------
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  // Pointers wrap explicitly at FIFO_DEPTH-1 so non-power-of-two depths
  // use exactly FIFO_DEPTH storage slots.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] count_upd(input logic [CNT_W-1:0] cnt,
                                                 input logic             wr,
                                                 input logic             rd);
    return cnt + CNT_W'(wr) - CNT_W'(rd);
  endfunction

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status flags are pure decodes of count; thresholds act immediately.
  assign full        = (count == DEPTH_CNT);
  assign empty       = (count == '0);
  assign almostfull  = (count >= af_thresh);
  assign almostempty = (count <= ae_thresh);

  // A write into a full FIFO is still accepted when a read frees the slot in
  // the same cycle; the read side samples the old word before it is replaced.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  // ---- stage p0 -> p1: pointers, count and request pulses -------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      count     <= count_upd(count, wr_acc, rd_acc);
      wr_ack    <= wr_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

  // Storage is deliberately not cleared by reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally; empty forces a clean zero.
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  logic [FIFO_WIDTH-1:0] rd_data_p1;

  // ---- stage p0 -> p1: registered read data, held between reads -------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
    end else if (rd_acc) begin
      rd_data_p1 <= mem[rd_ptr];
    end
  end

  assign data_out = rd_data_p1;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

  logic clk;
  logic rst_n;

  // depth-8 instance (a)
  logic [15:0] data_in_a, data_out_a;
  logic        wr_en_a, rd_en_a;
  logic [3:0]  af_a, ae_a, count_a;
  logic        wr_ack_a, overflow_a, underflow_a;
  logic        full_a, empty_a, afull_a, aempty_a;

  // depth-5 instance (b)
  logic [15:0] data_in_b, data_out_b;
  logic        wr_en_b, rd_en_b;
  logic [2:0]  af_b, ae_b, count_b;
  logic        wr_ack_b, overflow_b, underflow_b;
  logic        full_b, empty_b, afull_b, aempty_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] q_b[$];
  logic [15:0] exp_w;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in_a), .wr_en(wr_en_a),
    .rd_en(rd_en_a), .af_thresh(af_a), .ae_thresh(ae_a),
    .data_out(data_out_a), .wr_ack(wr_ack_a), .overflow(overflow_a),
    .underflow(underflow_a), .full(full_a), .empty(empty_a),
    .almostfull(afull_a), .almostempty(aempty_a), .count(count_a)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in_b), .wr_en(wr_en_b),
    .rd_en(rd_en_b), .af_thresh(af_b), .ae_thresh(ae_b),
    .data_out(data_out_b), .wr_ack(wr_ack_b), .overflow(overflow_b),
    .underflow(underflow_b), .full(full_b), .empty(empty_b),
    .almostfull(afull_b), .almostempty(aempty_b), .count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    data_in_a = '0; wr_en_a = 1'b0; rd_en_a = 1'b0; af_a = 4'd6; ae_a = 4'd2;
    data_in_b = '0; wr_en_b = 1'b0; rd_en_b = 1'b0; af_b = 3'd5; ae_b = 3'd0;
    #2;

    // ---- 1: reset with both requests held high
    rst_n = 1'b0;
    wr_en_a = 1'b1; rd_en_a = 1'b1; data_in_a = 16'h1234;
    wr_en_b = 1'b1; rd_en_b = 1'b1; data_in_b = 16'h4321;
    tick();
    check("rst_count", count_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_wr_ack", wr_ack_a, 0);
    check("rst_overflow", overflow_a, 0);
    check("rst_underflow", underflow_a, 0);
    check("rst_data_out", data_out_a, 0);
    check("rst_count_b", count_b, 0);
    rst_n = 1'b1;
    wr_en_a = 1'b0; rd_en_a = 1'b0;
    wr_en_b = 1'b0; rd_en_b = 1'b0;
    tick();
    check("idle_pulses", {wr_ack_a, overflow_a, underflow_a}, 0);

    // af_thresh=0 forces almostfull even when empty
    af_a = 4'd0; #1;
    check("af0_forced", afull_a, 1);
    af_a = 4'd6; #1;
    check("af6_empty", afull_a, 0);

    // ---- 2: fill 0x0001..0x0008
    for (int i = 1; i <= 8; i++) begin
      data_in_a = 16'(i); wr_en_a = 1'b1;
      tick();
      check($sformatf("fill_count_%0d", i), count_a, i);
      check($sformatf("fill_ack_%0d", i), wr_ack_a, 1);
      check($sformatf("fill_afull_%0d", i), afull_a, (i >= 6));
      check($sformatf("fill_full_%0d", i), full_a, (i == 8));
      check($sformatf("fill_aempty_%0d", i), aempty_a, (i <= 2));
    end
    data_in_a = 16'h0009;
    tick();
    check("ovf_overflow", overflow_a, 1);
    check("ovf_wr_ack", wr_ack_a, 0);
    check("ovf_count", count_a, 8);
    wr_en_a = 1'b0;
    tick();
    check("ovf_pulse_clear", overflow_a, 0);

    // ---- 3: drain in order
    for (int i = 1; i <= 8; i++) begin
      rd_en_a = 1'b1;
`ifdef FIFO_FWFT_EN
      check($sformatf("drain_data_%0d", i), data_out_a, i);
      tick();
`else
      tick();
      check($sformatf("drain_data_%0d", i), data_out_a, i);
`endif
      check($sformatf("drain_count_%0d", i), count_a, 8 - i);
      check($sformatf("drain_aempty_%0d", i), aempty_a, ((8 - i) <= 2));
    end
    tick();
    check("udf_underflow", underflow_a, 1);
    check("udf_empty", empty_a, 1);
`ifdef FIFO_FWFT_EN
    check("udf_data_zero", data_out_a, 0);
`else
    check("udf_data_hold", data_out_a, 16'h0008);
`endif
    rd_en_a = 1'b0;
    tick();
    check("udf_pulse_clear", underflow_a, 0);

    // ---- 4: full pass-through with 0xBEEF
    for (int i = 0; i < 8; i++) begin
      data_in_a = 16'h0011 + 16'(i); wr_en_a = 1'b1;
      tick();
    end
    wr_en_a = 1'b0;
    check("refill_full", full_a, 1);
    ae_a = 4'd8; #1;
    check("ae_depth_forced", aempty_a, 1);
    ae_a = 4'd2; #1;
    check("ae2_full", aempty_a, 0);

    data_in_a = 16'hBEEF; wr_en_a = 1'b1; rd_en_a = 1'b1;
`ifdef FIFO_FWFT_EN
    check("pass_head", data_out_a, 16'h0011);
    tick();
`else
    tick();
    check("pass_head", data_out_a, 16'h0011);
`endif
    check("pass_wr_ack", wr_ack_a, 1);
    check("pass_overflow", overflow_a, 0);
    check("pass_count", count_a, 8);
    wr_en_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
`ifdef FIFO_FWFT_EN
      check($sformatf("pass_rd_%0d", i), data_out_a, 16'h0012 + 16'(i));
      tick();
`else
      tick();
      check($sformatf("pass_rd_%0d", i), data_out_a, 16'h0012 + 16'(i));
`endif
    end
`ifdef FIFO_FWFT_EN
    check("pass_beef", data_out_a, 16'hBEEF);
    tick();
`else
    tick();
    check("pass_beef", data_out_a, 16'hBEEF);
`endif
    rd_en_a = 1'b0;
    check("pass_empty", empty_a, 1);

    // ---- 5: depth-5 wrap, prefill 4 then 12 write/read pairs
    for (int i = 0; i < 4; i++) begin
      data_in_b = 16'h0200 + 16'(i); wr_en_b = 1'b1;
      q_b.push_back(data_in_b);
      tick();
    end
    check("wrap_prefill", count_b, 4);
    for (int k = 0; k < 12; k++) begin
      data_in_b = 16'h0100 + 16'(k); wr_en_b = 1'b1; rd_en_b = 1'b0;
      q_b.push_back(data_in_b);
      tick();
      check($sformatf("wrap_ack_%0d", k), wr_ack_b, 1);
      check($sformatf("wrap_full_%0d", k), full_b, 1);
      check($sformatf("wrap_cnt_max_%0d", k), (count_b <= 3'd5), 1);
      wr_en_b = 1'b0; rd_en_b = 1'b1;
      exp_w = q_b.pop_front();
`ifdef FIFO_FWFT_EN
      check($sformatf("wrap_data_%0d", k), data_out_b, exp_w);
      tick();
`else
      tick();
      check($sformatf("wrap_data_%0d", k), data_out_b, exp_w);
`endif
      check($sformatf("wrap_count_%0d", k), count_b, 4);
    end
    rd_en_b = 1'b0;

    // ---- reset mid-operation discards entries
    for (int i = 0; i < 2; i++) begin
      data_in_a = 16'h0770 + 16'(i); wr_en_a = 1'b1;
      tick();
    end
    wr_en_a = 1'b0;
    check("mid_count_pre", count_a, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_count", count_a, 0);
    check("mid_rst_empty", empty_a, 1);
    check("mid_rst_data", data_out_a, 0);
    check("mid_rst_count_b", count_b, 0);

    // ---- 6: single write then single read
    data_in_a = 16'h00A5; wr_en_a = 1'b1;
    tick();
    wr_en_a = 1'b0;
    check("single_count", count_a, 1);
`ifdef FIFO_FWFT_EN
    check("fwft_show", data_out_a, 16'h00A5);
`endif
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
    check("single_empty", empty_a, 1);
`ifdef FIFO_FWFT_EN
    check("fwft_zero", data_out_a, 0);
`else
    check("single_data", data_out_a, 16'h00A5);
`endif
    check("single_no_udf", underflow_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
